// File: rtl/proximity_alert_scheduler.sv
// proximity_alert_scheduler: distance sample -> flash/buzzer PWM divide + enable.
// One shift-add multiplier shared by both channels; updates land on PWM period ends.
module proximity_alert_scheduler #(
  parameter int WIDTH              = 13,
  parameter int DIV_WIDTH          = 16,
  parameter int SCALE_WIDTH        = 8,
  parameter int MAX_FLASH_DISTANCE = 2000,
  parameter int MIN_FLASH_DISTANCE = 0,
  parameter int FLASH_HIGH_DIV     = 5000,
  parameter int FLASH_SCALE        = 10,
  parameter int BUZZ_HIGH_DIV      = 40,
  parameter int BUZZ_SCALE         = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     distance,
  output logic                 sample_ready,
  input  logic                 flash_period_done,
  input  logic                 buzz_period_done,
  output logic [DIV_WIDTH-1:0] flash_div,
  output logic                 flash_en,
  output logic [DIV_WIDTH-1:0] buzz_div,
  output logic                 buzz_en,
  output logic                 busy
);

  localparam int PW = WIDTH + SCALE_WIDTH + 1;
  localparam int CW = (SCALE_WIDTH > 1) ? $clog2(SCALE_WIDTH) : 1;
  localparam int W1 = WIDTH + 1;

  localparam logic [CW-1:0]          LAST  = CW'(SCALE_WIDTH - 1);
  localparam logic [WIDTH-1:0]       MINV  = WIDTH'(MIN_FLASH_DISTANCE);
  localparam logic [W1-1:0]          MAXV  = W1'(MAX_FLASH_DISTANCE);
  localparam logic [SCALE_WIDTH-1:0] FSC   = SCALE_WIDTH'(FLASH_SCALE);
  localparam logic [SCALE_WIDTH-1:0] BSC   = SCALE_WIDTH'(BUZZ_SCALE);
  localparam logic [PW-1:0]          FHIGH = PW'(FLASH_HIGH_DIV);
  localparam logic [PW-1:0]          BHIGH = PW'(BUZZ_HIGH_DIV);
  localparam logic [PW-1:0]          DMAX  = PW'((64'd1 << DIV_WIDTH) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    CALC_FLASH,
    CALC_BUZZ,
    STAGE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     offset;
  logic                 out_of_range;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        acc;
  logic [PW-1:0]        addend;
  logic [PW-1:0]        sum;
  logic [PW-1:0]        div_full;
  logic                 scale_bit;
  logic [DIV_WIDTH-1:0] flash_calc;
  logic [DIV_WIDTH-1:0] buzz_calc;
  logic [DIV_WIDTH-1:0] staged_flash_div;
  logic [DIV_WIDTH-1:0] staged_buzz_div;
  logic                 staged_en;
  logic                 flash_pend;
  logic                 buzz_pend;
  logic                 flash_apply;
  logic                 buzz_apply;

  function automatic logic [DIV_WIDTH-1:0] sat(input logic [PW-1:0] v);
    if (v > DMAX) return '1;
    return v[DIV_WIDTH-1:0];
  endfunction

  always_comb begin
    scale_bit = 1'b0;
    if (state == CALC_FLASH)
      scale_bit = FSC[cnt];
    else if (state == CALC_BUZZ)
      scale_bit = BSC[cnt];
  end

  // One scale bit per edge, LSB first: acc += offset << bit_index.
  assign addend   = PW'(offset) << cnt;
  assign sum      = scale_bit ? acc + addend : acc;
  assign div_full = sum + ((state == CALC_BUZZ) ? BHIGH : FHIGH);

  assign flash_apply  = flash_pend & (flash_period_done | ~flash_en);
  assign buzz_apply   = buzz_pend & (buzz_period_done | ~buzz_en);
  assign sample_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      offset           <= '0;
      out_of_range     <= 1'b0;
      cnt              <= '0;
      acc              <= '0;
      flash_calc       <= '0;
      buzz_calc        <= '0;
      staged_flash_div <= '0;
      staged_buzz_div  <= '0;
      staged_en        <= 1'b0;
      flash_pend       <= 1'b0;
      buzz_pend        <= 1'b0;
      flash_div        <= '0;
      flash_en         <= 1'b0;
      buzz_div         <= '0;
      buzz_en          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample_valid) begin
            offset       <= (distance > MINV) ? distance - MINV : '0;
            out_of_range <= ({1'b0, distance} >= MAXV);
            acc          <= '0;
            cnt          <= '0;
            state        <= CALC_FLASH;
          end
        end
        CALC_FLASH: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            flash_calc <= sat(div_full);
            acc        <= '0;
            cnt        <= '0;
            state      <= CALC_BUZZ;
          end
        end
        CALC_BUZZ: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            buzz_calc <= sat(div_full);
            acc       <= '0;
            cnt       <= '0;
            state     <= STAGE;
          end
        end
        STAGE: begin
          staged_flash_div <= flash_calc;
          staged_buzz_div  <= buzz_calc;
          staged_en        <= ~out_of_range;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A disable keeps the last divide so the PWM stops on a known value.
      if (flash_apply) begin
        flash_en <= staged_en;
        if (staged_en)
          flash_div <= staged_flash_div;
      end
      if (buzz_apply) begin
        buzz_en <= staged_en;
        if (staged_en)
          buzz_div <= staged_buzz_div;
      end

      flash_pend <= (state == STAGE) | (flash_pend & ~flash_apply);
      buzz_pend  <= (state == STAGE) | (buzz_pend & ~buzz_apply);
    end
  end

endmodule

// File: tb/tb_proximity_alert_scheduler.sv
// tb_proximity_alert_scheduler: table vectors, directed corner sequences,
// and a random run against a latency/pending reference model.
module tb_proximity_alert_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [12:0] distance = '0;
  logic        flash_period_done = 1'b0;
  logic        buzz_period_done = 1'b0;
  logic        sample_ready;
  logic [15:0] flash_div;
  logic        flash_en;
  logic [15:0] buzz_div;
  logic        buzz_en;
  logic        busy;

  logic        s_valid = 1'b0;
  logic [12:0] s_distance = '0;
  logic        s_pd = 1'b0;
  logic        s_ready;
  logic [15:0] s_fdiv;
  logic        s_fen;
  logic [15:0] s_bdiv;
  logic        s_ben;
  logic        s_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  proximity_alert_scheduler dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .distance(distance),
    .sample_ready(sample_ready),
    .flash_period_done(flash_period_done),
    .buzz_period_done(buzz_period_done),
    .flash_div(flash_div),
    .flash_en(flash_en),
    .buzz_div(buzz_div),
    .buzz_en(buzz_en),
    .busy(busy)
  );

  proximity_alert_scheduler #(.FLASH_SCALE(255)) dut_sat (
    .clk(clk),
    .reset(reset),
    .sample_valid(s_valid),
    .distance(s_distance),
    .sample_ready(s_ready),
    .flash_period_done(s_pd),
    .buzz_period_done(s_pd),
    .flash_div(s_fdiv),
    .flash_en(s_fen),
    .buzz_div(s_bdiv),
    .buzz_en(s_ben),
    .busy(s_busy)
  );

  // Reference model: result known at acceptance, staged 17 edges later,
  // applied per channel by the pending/period rule.
  int m_cd = 0;
  int m_cfd = 0, m_cbd = 0;
  bit m_cen = 0;
  int m_sfd = 0, m_sbd = 0;
  bit m_sen = 0;
  bit m_fpend = 0, m_bpend = 0;
  int m_fdiv = 0, m_bdiv = 0;
  bit m_fen = 0, m_ben = 0;

  function automatic int div_of(input int d, input int high, input int scale);
    longint v;
    v = longint'(high) + longint'(d) * longint'(scale);
    return (v > 65535) ? 65535 : int'(v);
  endfunction

  task automatic model_edge();
    bit af, ab;
    if (reset) begin
      m_cd = 0; m_cfd = 0; m_cbd = 0; m_cen = 0;
      m_sfd = 0; m_sbd = 0; m_sen = 0;
      m_fpend = 0; m_bpend = 0;
      m_fdiv = 0; m_bdiv = 0; m_fen = 0; m_ben = 0;
    end else begin
      af = m_fpend && (flash_period_done || !m_fen);
      ab = m_bpend && (buzz_period_done || !m_ben);
      if (af) begin
        if (m_sen) m_fdiv = m_sfd;
        m_fen = m_sen;
        m_fpend = 0;
      end
      if (ab) begin
        if (m_sen) m_bdiv = m_sbd;
        m_ben = m_sen;
        m_bpend = 0;
      end
      if (m_cd == 1) begin
        m_sfd = m_cfd; m_sbd = m_cbd; m_sen = m_cen;
        m_fpend = 1; m_bpend = 1;
      end
      if (m_cd != 0) begin
        m_cd--;
      end else if (sample_valid) begin
        m_cd = 17;
        m_cfd = div_of(int'(distance), 5000, 10);
        m_cbd = div_of(int'(distance), 40, 1);
        m_cen = (int'(distance) < 2000);
      end
    end
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic offer(input int d);
    distance = 13'(d);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse(input bit f, input bit b);
    flash_period_done = f;
    buzz_period_done = b;
    tick();
    flash_period_done = 1'b0;
    buzz_period_done = 1'b0;
  endtask

  task automatic outs(input string nm, input int fd, input int bd,
                      input bit fe, input bit be);
    check({nm, "_fdiv"}, flash_div, fd);
    check({nm, "_bdiv"}, buzz_div, bd);
    check({nm, "_fen"}, flash_en, fe);
    check({nm, "_ben"}, buzz_en, be);
  endtask

  typedef struct {
    int d;
    int fdiv;
    int bdiv;
    bit en;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1000, 15000, 1040, 1'b1};
    tbl[1] = '{0,    5000,  40,   1'b1};
    tbl[2] = '{1999, 24990, 2039, 1'b1};
    tbl[3] = '{500,  10000, 540,  1'b1};
    tbl[4] = '{1,    5010,  41,   1'b1};
    tbl[5] = '{2000, 0,     0,    1'b0};
    tbl[6] = '{2500, 0,     0,    1'b0};

    do_reset();
    outs("reset", 0, 0, 0, 0);
    check("reset_ready", sample_ready, 1);
    check("reset_busy", busy, 0);

    foreach (tbl[i]) begin
      do_reset();
      check("tbl_ready_idle", sample_ready, 1);
      offer(tbl[i].d);
      check("tbl_ready_e0", sample_ready, 0);
      check("tbl_busy_e0", busy, 1);
      repeat (16) tick();
      check("tbl_busy_e16", busy, 1);
      tick();
      check("tbl_busy_e17", busy, 0);
      check("tbl_fen_e17", flash_en, 0);
      tick();
      outs("tbl_e18", tbl[i].fdiv, tbl[i].bdiv, tbl[i].en, tbl[i].en);
    end

    // Enabled channels hold until their own period_done.
    do_reset();
    offer(1000);
    repeat (18) tick();
    outs("hold_base", 15000, 1040, 1, 1);
    offer(500);
    repeat (18) tick();
    outs("hold_e18", 15000, 1040, 1, 1);
    repeat (5) tick();
    outs("hold_late", 15000, 1040, 1, 1);
    pulse(1, 0);
    outs("hold_flash", 10000, 1040, 1, 1);
    pulse(0, 1);
    outs("hold_buzz", 10000, 540, 1, 1);

    // Disable keeps the divides and waits for period_done.
    offer(2500);
    repeat (18) tick();
    outs("dis_wait", 10000, 540, 1, 1);
    pulse(1, 1);
    outs("dis_apply", 10000, 540, 0, 0);
    pulse(1, 1);
    outs("dis_stray", 10000, 540, 0, 0);

    // Simultaneous STAGE and apply.
    do_reset();
    offer(1000);
    repeat (18) tick();
    offer(500);
    repeat (17) tick();
    offer(1999);
    repeat (16) tick();
    outs("sim_pre", 15000, 1040, 1, 1);
    pulse(1, 0);
    outs("sim_old", 10000, 1040, 1, 1);
    pulse(1, 0);
    outs("sim_new", 24990, 1040, 1, 1);
    pulse(0, 1);
    outs("sim_buzz", 24990, 2039, 1, 1);

    // Reset during CALC_BUZZ.
    do_reset();
    offer(1000);
    repeat (10) tick();
    check("rcalc_busy", busy, 1);
    do_reset();
    outs("rcalc", 0, 0, 0, 0);
    check("rcalc_ready", sample_ready, 1);
    pulse(1, 1);
    repeat (20) tick();
    outs("rcalc_after", 0, 0, 0, 0);

    // Reset while pending.
    do_reset();
    offer(1000);
    repeat (18) tick();
    offer(500);
    repeat (18) tick();
    outs("rpend_pre", 15000, 1040, 1, 1);
    do_reset();
    outs("rpend", 0, 0, 0, 0);
    check("rpend_ready", sample_ready, 1);
    pulse(1, 1);
    outs("rpend_after", 0, 0, 0, 0);

    // Saturated flash path.
    do_reset();
    s_distance = 13'd1999;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (18) tick();
    check("sat_fdiv", s_fdiv, 65535);
    check("sat_bdiv", s_bdiv, 2039);
    check("sat_fen", s_fen, 1);

    // Random run against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 3));
      case (r)
        0: distance = 13'($urandom_range(0, 2100));
        1: distance = 13'($urandom_range(1998, 2001));
        2: distance = 13'($urandom_range(0, 8191));
        default: distance = 13'($urandom_range(0, 10));
      endcase
      sample_valid = ($urandom_range(0, 3) == 0);
      flash_period_done = ($urandom_range(0, 7) == 0);
      buzz_period_done = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
      check("rnd_fdiv", flash_div, m_fdiv);
      check("rnd_bdiv", buzz_div, m_bdiv);
      check("rnd_fen", flash_en, m_fen);
      check("rnd_ben", buzz_en, m_ben);
      check("rnd_ready", sample_ready, (m_cd == 0));
      check("rnd_busy", busy, (m_cd != 0));
    end
    reset = 1'b0;
    sample_valid = 1'b0;
    flash_period_done = 1'b0;
    buzz_period_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
